// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer:
//   - stall vector width and per-stage bit positions
//   - sequencer state encoding
//   - small helper for the "fetch still in flight" condition
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int STALL_W    = 4;
  localparam int STALL_INST = 3;
  localparam int STALL_ID   = 2;
  localparam int STALL_EX   = 1;
  localparam int STALL_DATA = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_FLUSH_WAIT = 2'd1,
    ST_DISCARD    = 2'd2
  } state_e;

  // A fetch issued before the flush is still on its way back and will
  // return an instruction from the squashed path.
  function automatic logic fetch_in_flight(input logic req_pending, input logic resp);
    return req_pending & ~resp;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_perf
// Stall/flush performance counter bank. Each counter adds one on every cycle
// its increment input is high and wraps naturally at 2^PERF_W.
// Ports:
//   clk, rst            clock, synchronous active-high reset (counters -> 0)
//   inc_if_i            fetch-stall cycle
//   inc_data_i          data-stall cycle
//   inc_flush_i         flush cycle
//   perf_if_stall_o     fetch-stall cycle count
//   perf_data_stall_o   data-stall cycle count
//   perf_flush_o        flush count
// -----------------------------------------------------------------------------
module pipe_ctrl_perf #(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_if_i,
  input  logic              inc_data_i,
  input  logic              inc_flush_i,
  output logic [PERF_W-1:0] perf_if_stall_o,
  output logic [PERF_W-1:0] perf_data_stall_o,
  output logic [PERF_W-1:0] perf_flush_o
);

  logic [PERF_W-1:0] if_cnt_q,    if_cnt_d;
  logic [PERF_W-1:0] data_cnt_q,  data_cnt_d;
  logic [PERF_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    if_cnt_d    = if_cnt_q    + PERF_W'(inc_if_i);
    data_cnt_d  = data_cnt_q  + PERF_W'(inc_data_i);
    flush_cnt_d = flush_cnt_q + PERF_W'(inc_flush_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if_cnt_q    <= '0;
      data_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else begin
      if_cnt_q    <= if_cnt_d;
      data_cnt_q  <= data_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_if_stall_o   = if_cnt_q;
  assign perf_data_stall_o = data_cnt_q;
  assign perf_flush_o      = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Central stall/flush sequencer for the five-stage core.
//   - Merges per-stage stall requests into stall_o {inst, id, ex, data}.
//   - Turns a committed exception/ERET into a one-cycle flush + redirect PC.
//   - Holds the flush off (full stall) while a data-bus access is outstanding.
//   - Marks the next returned instruction for discard when a fetch issued
//     down the squashed path is still in flight.
// Optional build macro: PIPE_CTRL_PERF_EN adds perf_if_stall, perf_data_stall
// and perf_flush counters (PERF_W bits each, wrapping).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   if_stall_req        fetch cannot deliver this cycle
//   if_req_pending      instruction-bus transaction outstanding
//   if_resp             instruction-bus response pulse
//   id_stall_req        load-use hazard
//   ex_stall_req        multi-cycle EX busy
//   mem_stall_req       data-bus wait
//   mem_req_pending     data-bus transaction outstanding
//   flush_req, flush_pc exception/ERET commit and its target
//   stall_o             stall vector {inst, id, ex, data}
//   flush_o, flush_pc_o flush strobe and redirect target
//   inst_discard_o      drop the next returned instruction
//   busy_o              sequencer not idle
// -----------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int PC_W   = 32,
  parameter int PERF_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               if_req_pending,
  input  logic               if_resp,
  input  logic               id_stall_req,
  input  logic               ex_stall_req,
  input  logic               mem_stall_req,
  input  logic               mem_req_pending,
  input  logic               flush_req,
  input  logic [PC_W-1:0]    flush_pc,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [PC_W-1:0]    flush_pc_o,
  output logic               inst_discard_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic               busy_o,
  output logic [PERF_W-1:0]  perf_if_stall,
  output logic [PERF_W-1:0]  perf_data_stall,
  output logic [PERF_W-1:0]  perf_flush
`else
  output logic               busy_o
`endif
);

  if (PC_W < 1 || PERF_W < 1) begin : g_param_check
    $error("pipe_ctrl: PC_W and PERF_W must be at least 1");
  end

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q,    pc_d;

  logic [STALL_W-1:0] stall_req;
  logic [STALL_W-1:0] stall_c;
  logic               flush_c;
  logic [PC_W-1:0]    flush_pc_c;
  logic               discard_c;

  always_comb begin
    stall_req             = '0;
    stall_req[STALL_INST] = if_stall_req;
    stall_req[STALL_ID]   = id_stall_req;
    stall_req[STALL_EX]   = ex_stall_req;
    stall_req[STALL_DATA] = mem_stall_req;
  end

  // NOTE: every signal assigned in this block gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    stall_c    = stall_req;
    flush_c    = 1'b0;
    flush_pc_c = '0;
    discard_c  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (flush_req) begin
          if (!mem_req_pending) begin
            flush_c    = 1'b1;
            flush_pc_c = flush_pc;
            stall_c    = '0;
            state_d    = fetch_in_flight(if_req_pending, if_resp) ? ST_DISCARD : ST_IDLE;
          end else begin
            pc_d    = flush_pc;
            stall_c = '1;
            state_d = ST_FLUSH_WAIT;
          end
        end
      end

      ST_FLUSH_WAIT: begin
        // flush_req is ignored here: the captured (older) exception wins.
        if (mem_req_pending) begin
          stall_c = '1;
        end else begin
          flush_c    = 1'b1;
          flush_pc_c = pc_q;
          stall_c    = '0;
          state_d    = fetch_in_flight(if_req_pending, if_resp) ? ST_DISCARD : ST_IDLE;
        end
      end

      ST_DISCARD: begin
        discard_c           = 1'b1;
        stall_c[STALL_INST] = 1'b1;
        if (flush_req) begin
          if (!mem_req_pending) begin
            flush_c    = 1'b1;
            flush_pc_c = flush_pc;
            stall_c    = '0;
            state_d    = fetch_in_flight(if_req_pending, if_resp) ? ST_DISCARD : ST_IDLE;
          end else begin
            pc_d    = flush_pc;
            stall_c = '1;
            state_d = ST_FLUSH_WAIT;
          end
        end else if (if_resp) begin
          // The squashed instruction is dropped this cycle; back to normal.
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch and the
  // sensitivity list carries only clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Outputs are held quiet during the reset cycle, whatever the inputs do.
  assign stall_o        = rst ? '0   : stall_c;
  assign flush_o        = rst ? 1'b0 : flush_c;
  assign flush_pc_o     = rst ? '0   : flush_pc_c;
  assign inst_discard_o = rst ? 1'b0 : discard_c;
  assign busy_o         = !rst && (state_q != ST_IDLE);

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf #(
    .PERF_W (PERF_W)
  ) u_perf (
    .clk               (clk),
    .rst               (rst),
    .inc_if_i          (stall_o[STALL_INST]),
    .inc_data_i        (stall_o[STALL_DATA]),
    .inc_flush_i       (flush_o),
    .perf_if_stall_o   (perf_if_stall),
    .perf_data_stall_o (perf_data_stall),
    .perf_flush_o      (perf_flush)
  );
`endif

endmodule
